// File: rtl/tdm_demux4.sv
// Four-slot serial TDM demultiplexer: collects MSB-first slots after a sync
// strobe and publishes all four channels together once a frame is complete.
module tdm_demux4 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          sync,
  output logic [DW-1:0] ch0,
  output logic [DW-1:0] ch1,
  output logic [DW-1:0] ch2,
  output logic [DW-1:0] ch3,
  output logic          frame_valid,
  output logic          sync_err,
  output logic          busy
);
  localparam int BW = (DW > 2) ? $clog2(DW) : 1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t                 state;
  logic [BW-1:0]          bit_cnt;
  logic [1:0]             slot_cnt;
  logic [DW-1:0]          sr;
  logic [2:0][DW-1:0]     hold;
  logic [3:0][DW-1:0]     chq;
  logic [DW-1:0]          assembled;
  logic [DW-1:0]          first_bit;
  logic                   last_bit;

  assign assembled = {sr[DW-2:0], din};
  assign first_bit = {{(DW-1){1'b0}}, din};
  assign last_bit  = (bit_cnt == BW'(DW-1));
  assign busy      = (state == RECV);

  assign ch0 = chq[0];
  assign ch1 = chq[1];
  assign ch2 = chq[2];
  assign ch3 = chq[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      sr          <= '0;
      hold        <= '0;
      chq         <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            sr       <= first_bit;
            bit_cnt  <= BW'(1);
            slot_cnt <= '0;
            state    <= RECV;
          end
        end
        RECV: begin
          if (sync) begin
            // Mid-frame sync: drop the partial frame and restart on this bit.
            sync_err <= 1'b1;
            sr       <= first_bit;
            bit_cnt  <= BW'(1);
            slot_cnt <= '0;
          end else begin
            sr <= assembled;
            if (last_bit) begin
              bit_cnt <= '0;
              if (slot_cnt == 2'd3) begin
                chq         <= {assembled, hold[2], hold[1], hold[0]};
                frame_valid <= 1'b1;
                state       <= IDLE;
              end else begin
                hold[slot_cnt] <= assembled;
                slot_cnt       <= slot_cnt + 2'd1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: DW=8 instance for frame traffic, DW=4
// instance for the narrow build.
module tb_tdm_demux4;
  logic gclk = 1'b0;
  logic rst_n, din, sync, din4, sync4;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic [3:0] c40, c41, c42, c43;
  logic fv, serr, busy, fv4, serr4, busy4;

  always #5 gclk = ~gclk;

  tdm_demux4 #(.DW(8)) dut (
    .clk(gclk), .rst_n(rst_n), .din(din), .sync(sync),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .frame_valid(fv), .sync_err(serr), .busy(busy)
  );

  tdm_demux4 #(.DW(4)) dut4 (
    .clk(gclk), .rst_n(rst_n), .din(din4), .sync(sync4),
    .ch0(c40), .ch1(c41), .ch2(c42), .ch3(c43),
    .frame_valid(fv4), .sync_err(serr4), .busy(busy4)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;
  int cyc = 0, fv_cnt = 0, err_cnt = 0, busy_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  always @(posedge gclk) cyc <= cyc + 1;

  // Output monitor: every frame_valid pulse must match the oldest expected frame.
  always @(negedge gclk) begin
    if (busy) busy_cnt++;
    if (serr) err_cnt++;
    if (fv && serr) chk("fv_serr_excl", 1, 0);
    if (fv) begin
      fv_cnt++;
      if (q.size() == 0) chk("fv_unexpected", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("frame", {ch0, ch1, ch2, ch3}, e.data);
        chk("fv_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send8(input logic [31:0] bits, input int nbits, input bit push, input bit chkbusy);
    for (int i = 0; i < nbits; i++) begin
      @(negedge gclk);
      if (chkbusy && i > 0) chk("busy_in_frame", busy, 1);
      sync = (i == 0);
      din  = bits[31-i];
      if (i == 0 && push) begin
        exp_t e;
        e.data = bits;
        e.cyc  = cyc + 32;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle8(input int n);
    repeat (n) begin
      @(negedge gclk);
      sync = 1'b0;
      din  = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int f0, e0, b0;
    logic [15:0] f4;
    rst_n = 1'b0; din = 1'b0; sync = 1'b0; din4 = 1'b0; sync4 = 1'b0;
    #3;
    chk("rst_ch", {ch0, ch1, ch2, ch3}, 32'h0);
    chk("rst_flags", {29'd0, fv, serr, busy}, 32'h0);
    repeat (2) @(negedge gclk);
    rst_n = 1'b1;

    // Idle line with toggling data must be ignored.
    f0 = fv_cnt; e0 = err_cnt; b0 = busy_cnt;
    for (int i = 0; i < 100; i++) begin
      @(negedge gclk);
      din = i[0];
    end
    idle8(1);
    chk("idle_ch", {ch0, ch1, ch2, ch3}, 32'h0);
    chk("idle_busy", busy_cnt - b0, 0);
    chk("idle_fv", fv_cnt - f0, 0);
    chk("idle_err", err_cnt - e0, 0);

    // Single frame with busy tracking.
    f0 = fv_cnt;
    send8(32'hA53C0F81, 32, 1, 1);
    @(negedge gclk);
    chk("busy_after", busy, 0);
    chk("fv_pulse", fv, 1);
    sync = 1'b0;
    idle8(3);
    chk("fv_count1", fv_cnt - f0, 1);
    chk("hold_ch", {ch0, ch1, ch2, ch3}, 32'hA53C0F81);

    // Back-to-back frames.
    f0 = fv_cnt;
    send8(32'h11223344, 32, 1, 0);
    send8(32'h55667788, 32, 1, 0);
    idle8(3);
    chk("b2b_fv_count", fv_cnt - f0, 2);
    chk("b2b_final", {ch0, ch1, ch2, ch3}, 32'h55667788);

    // Sync at bit 10 aborts the frame and starts a new one.
    f0 = fv_cnt; e0 = err_cnt;
    send8(32'h12345678, 10, 0, 0);
    send8(32'hDEADBEEF, 32, 1, 0);
    idle8(3);
    chk("abort_err_count", err_cnt - e0, 1);
    chk("abort_fv_count", fv_cnt - f0, 1);

    // Asynchronous reset mid-frame, then sync on the first edge after release.
    send8(32'h0BADF00D, 20, 0, 0);
    @(negedge gclk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ch", {ch0, ch1, ch2, ch3}, 32'h0);
    chk("async_rst_flags", {29'd0, fv, serr, busy}, 32'h0);
    @(posedge gclk);
    #1 rst_n = 1'b1;
    f0 = fv_cnt;
    send8(32'hCAFE1234, 32, 1, 0);
    idle8(3);
    chk("post_rst_fv_count", fv_cnt - f0, 1);

    // Narrow build.
    f4 = 16'hA5F0;
    for (int i = 0; i < 16; i++) begin
      @(negedge gclk);
      if (i == 15) chk("fv4_early", fv4, 0);
      sync4 = (i == 0);
      din4  = f4[15-i];
    end
    @(negedge gclk);
    sync4 = 1'b0;
    chk("fv4", fv4, 1);
    chk("dw4_frame", {16'd0, c40, c41, c42, c43}, {16'd0, f4});
    @(negedge gclk);
    chk("fv4_single", fv4, 0);

    chk("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 SHALL have parameter DW, default 8, giving the bits per channel slot; legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port din, input, 1 bit, serial TDM data, MSB of each slot first.
REQ-005 SHALL have port sync, input, 1 bit, high for the one cycle that carries bit DW-1 of slot 0.
REQ-006 SHALL have ports ch0, ch1, ch2, ch3, each output, DW bits, the registered demultiplexed slot 0..3 data.
REQ-007 SHALL have port frame_valid, output, 1 bit, one-cycle pulse when ch0..ch3 hold a new complete frame.
REQ-008 SHALL have port sync_err, output, 1 bit, one-cycle pulse on a sync received mid-frame.
REQ-009 SHALL have port busy, output, 1 bit, high while state is RECV.

Function
REQ-010 SHALL define a frame as 4*DW consecutive cycles: slot 0 bits DW-1..0, then slot 1, slot 2, slot 3, one bit per cycle, with no idle cycles inside a frame.
REQ-011 SHALL implement the states IDLE and RECV, with a bit counter 0..DW-1 and a slot counter 0..3.
REQ-012 In IDLE with sync=0, SHALL ignore din and keep all outputs unchanged.
REQ-013 In IDLE with sync=1, SHALL capture din as bit DW-1 of slot 0, set bit count to 1 and slot to 0, and enter RECV.
REQ-014 In RECV with sync=0, SHALL shift din into a DW-bit shift register (MSB first) each cycle and increment the bit counter.
REQ-015 SHALL copy the assembled byte into internal hold register slot[n] on the cycle capturing bit 0 of slots 0..2, then wrap the bit counter to 0 and increment the slot counter.
REQ-016 On the cycle capturing bit 0 of slot 3, SHALL load ch0..ch3 simultaneously from the three hold registers plus the assembled slot 3 byte, assert frame_valid for exactly the next cycle, and return to IDLE.
REQ-017 SHALL not modify ch0..ch3 at any other time; the outputs hold the last good frame indefinitely.
REQ-018 SHALL accept back-to-back frames: sync=1 on the cycle immediately after the last bit of slot 3 starts a new frame with no lost bit, per REQ-013.
REQ-019 In RECV with sync=1, SHALL pulse sync_err for the next cycle, discard the partial frame, and treat that cycle as bit DW-1 of slot 0 of a new frame, staying in RECV.
REQ-020 SHALL not assert frame_valid for any frame aborted per REQ-019.
REQ-021 SHALL drive frame_valid and sync_err only from registers and never high together.

Reset
REQ-022 While rst_n=0, regardless of clk, SHALL force ch0..ch3=0, frame_valid=0, sync_err=0, busy=0, state IDLE, and counters, shift register and hold registers to 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait in IDLE for a fresh sync.
REQ-024 SHALL sample the first valid sync on the first rising clk edge after rst_n rises.

Verification
REQ-025 Reset, then sync on cycle 0 followed by frame bytes A5,3C,0F,81 (DW=8) -> at cycle 32, ch0=A5, ch1=3C, ch2=0F, ch3=81, and frame_valid is high for one cycle; busy is high for cycles 1..31.
REQ-026 Two back-to-back frames, 11,22,33,44 then 55,66,77,88 -> two frame_valid pulses 32 cycles apart; the outputs equal the second frame after the second pulse.
REQ-027 Frame 12,34,56,78 with a second sync at bit 10 -> sync_err pulse, no frame_valid; the new frame DE,AD,BE,EF starting at that sync is output correctly 32 cycles after it.
REQ-028 din toggling every cycle for 100 cycles with sync=0 -> busy=0, outputs remain 0, no pulses.
REQ-029 rst_n pulled low at cycle 20 of a frame -> all outputs 0 immediately, with no clk edge needed; a subsequent full frame decodes correctly.
REQ-030 DW=4 build with frame A,5,F,0 -> ch0..ch3=A,5,F,0 and frame_valid at cycle 16.
